// File: rtl/adc_byte_packer_pkg.sv
// adc_pkg: shared defaults and helpers for the ADC byte packer slice.
package adc_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4096;
  localparam int unsigned DROP_W     = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

  // Saturating increment for the dropped-word counter.
  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] cnt);
    logic [DROP_W-1:0] res;
    if (cnt == DROP_MAX) begin
      res = DROP_MAX;
    end else begin
      res = cnt + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_byte_packer_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous-read RAM and registered flags.
// A push while full is still accepted if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  dout_o,
  output logic              dout_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   level_o,
  output logic              push_ok_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             pop_do_s;
  logic             push_do_s;

  // Accept/advance decisions and next-state flags from the next pointers.
  always_comb begin
    pop_do_s  = pop_i & ~empty_q;
    push_do_s = push_i & (~full_q | pop_do_s);
    if (push_do_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_do_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
  end

  // RAM write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_do_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= din_i;
    end
  end

  // Pointers, flags and the registered read port.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      dout_valid_q <= pop_do_s;
      if (pop_do_s) begin
        dout_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign empty_o      = empty_q;
  assign full_o       = full_q;
  assign level_o      = level_q;
  assign push_ok_o    = push_do_s;

endmodule

// File: rtl/adc_byte_packer.sv
// adc_byte_packer: packs the gated serial ADC bit stream MSB-first into
// words, buffers them in a FIFO for host readout, and tracks dropped words.
module adc_byte_packer
  import adc_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              acq_en_i,
  input  logic              bit_in_i,
  input  logic              bit_valid_i,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int unsigned CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_s;
  logic              push_s;
  logic              push_ok_s;
  logic              drop_s;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Packer: shift in qualified bits; a full word is pushed on the last bit.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    push_s  = 1'b0;
    word_s  = {shreg_q[WORD_W-2:0], bit_in_i};
    if (!acq_en_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (bit_valid_i) begin
      shreg_d = word_s;
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        push_s = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Drop tracking: a drop in the same cycle as a clear wins and counts as one.
  always_comb begin
    drop_s     = push_s & ~push_ok_s;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (ovf_clr_i) begin
        drop_cnt_d = 16'd1;
      end else begin
        drop_cnt_d = drop_inc(drop_cnt_q);
      end
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Packer and overflow state registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .n_reset      (n_reset),
    .push_i       (push_s),
    .din_i        (word_s),
    .pop_i        (rd_en_i),
    .dout_o       (rd_data_o),
    .dout_valid_o (rd_valid_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .level_o      (level_o),
    .push_ok_o    (push_ok_s)
  );

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_adc_byte_packer.sv
// tb_adc_byte_packer: randomized, scoreboard-checked bench for adc_byte_packer
// (WORD_W=8, DEPTH=16) against a queue-based reference model.
module tb_adc_byte_packer;

  localparam int DEPTH = 16;

  logic        clk;
  logic        n_reset;
  logic        acq_en, bit_in, bit_valid, rd_en, ovf_clr;
  logic [7:0]  rd_data;
  logic        rd_valid, empty, full, overflow;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  adc_byte_packer #(.WORD_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .acq_en_i(acq_en), .bit_in_i(bit_in),
    .bit_valid_i(bit_valid), .rd_en_i(rd_en), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .empty_o(empty), .full_o(full), .level_o(level),
    .overflow_o(overflow), .ovf_clr_i(ovf_clr), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit        bits_q[$];
  bit [7:0]  mfifo[$];
  bit [7:0]  exp_q[$];
  bit        movf;
  bit [15:0] mdrop;
  bit [7:0]  mdata;
  bit        mon_en;
  int        total;
  int        bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, update model at the edge, check state after it.
  task automatic cycle(input logic acq, input logic bv, input logic b,
                       input logic rd, input logic clr, input logic rstn);
    bit       pop_ok;
    bit       got_word;
    bit [7:0] w;
    acq_en = acq; bit_valid = bv; bit_in = b; rd_en = rd; ovf_clr = clr; n_reset = rstn;
    @(posedge clk);
    if (!rstn) begin
      bits_q.delete(); mfifo.delete(); exp_q.delete();
      movf = 1'b0; mdrop = 16'd0; mdata = 8'd0;
    end else begin
      pop_ok   = rd && (mfifo.size() > 0);
      got_word = 1'b0;
      w        = 8'd0;
      if (!acq) begin
        bits_q.delete();
      end else if (bv) begin
        bits_q.push_back(b);
        if (bits_q.size() == 8) begin
          foreach (bits_q[i]) w = w * 2 + 8'(bits_q[i]);
          got_word = 1'b1;
          bits_q.delete();
        end
      end
      if (pop_ok) begin
        mdata = mfifo.pop_front();
        exp_q.push_back(mdata);
      end
      if (got_word && mfifo.size() < DEPTH) begin
        mfifo.push_back(w);
      end else if (got_word) begin
        movf  = 1'b1;
        mdrop = clr ? 16'd1 : ((mdrop == 16'hFFFF) ? mdrop : mdrop + 16'd1);
      end else if (clr) begin
        movf  = 1'b0;
        mdrop = 16'd0;
      end
    end
    #1;
    chk("level",    32'(level),    32'(mfifo.size()));
    chk("empty",    32'(empty),    32'(mfifo.size() == 0));
    chk("full",     32'(full),     32'(mfifo.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    chk("rd_data",  32'(rd_data),  32'(mdata));
  endtask

  task automatic send_word(input logic [7:0] w, input logic rd_last, input logic clr_last);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, 1'b1, w[i], (i == 0) ? rd_last : 1'b0, (i == 0) ? clr_last : 1'b0, 1'b1);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mfifo.size() > 0 && guard < 64) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      guard++;
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: rd_valid must appear exactly when a pop was expected last edge.
  initial begin
    bit [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          if (rd_valid !== 1'b1 || rd_data !== e) begin
            bad++;
            $display("FAIL rd_word: got valid=%b data=%0h expected valid=1 data=%0h at %0t",
                     rd_valid, rd_data, e, $time);
          end
        end else begin
          total++;
          if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_idle: got %b expected 0 at %0t", rd_valid, $time);
          end
        end
      end
    end
  end

  initial begin
    bit [7:0] w;
    int       sent;
    total = 0; bad = 0; mon_en = 1'b0;
    acq_en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    n_reset = 1'b0;

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Basic pack of 8'hA5, then one read
    send_word(8'hA5, 1'b0, 1'b0);
    drain();

    // Gapped valid with abort, then a clean 8'h3C
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0);
    drain();

    // Empty read is ignored
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Fill and overflow, then a drop coinciding with a clear
    for (int i = 0; i <= 16; i++) send_word(8'(i), 1'b0, 1'b0);
    send_word(8'hEE, 1'b0, 1'b1);
    send_word(8'hEF, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Final bit and read in the same cycle while full
    for (int i = 0; i < 16; i++) send_word(8'h40 + 8'(i), 1'b0, 1'b0);
    send_word(8'h77, 1'b1, 1'b0);
    drain();

    // 40 random words with gaps and interleaved reads across pointer wrap
    for (int k = 0; k < 40; k++) begin
      w = 8'($urandom);
      sent = 0;
      while (sent < 8) begin
        if ($urandom_range(0, 3) != 0) begin
          cycle(1'b1, 1'b1, w[7 - sent], 1'($urandom_range(0, 1)), 1'b0, 1'b1);
          sent++;
        end else begin
          cycle(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
      end
    end
    drain();

    // Random mix: aborts, clears, slow then fast readout
    for (int c = 0; c < 800; c++) begin
      cycle(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom), (c < 400) ? 1'($urandom_range(0, 19) == 0)
                                    : 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 39) == 0), 1'b1);
    end
    drain();

    // Reset mid-operation with a read pending, then a fresh word
    for (int i = 0; i < 3; i++) send_word(8'(8'h90 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
